// File: rtl/prbs_seq_pkg.sv
// Shared types for the PRBS sequencing controller: FSM states and phase codes.
package prbs_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT,
      PATT,
      PRBS,
      DONE
   } state_t;

   localparam logic [1:0] PH_IDLE = 2'b00;
   localparam logic [1:0] PH_PATT = 2'b01;
   localparam logic [1:0] PH_PRBS = 2'b10;
   localparam logic [1:0] PH_DONE = 2'b11;

endpackage

// File: rtl/prbs_seq_ctrl_cnt.sv
// Loadable down-counter that saturates at zero and reports a zero flag.
module seq_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // Load has priority; decrement stops at zero so the count never wraps.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (dec && !zero)
         cnt_q <= cnt_q - W'(1);
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/prbs_seq_ctrl.sv
// Sequencing controller for the pattern/PRBS-15 byte generator.
//
// state | meaning
// IDLE  | waiting for config / start, cfg_ready high
// ARM   | one-cycle gen_enable pulse, counters loaded
// WAIT  | generator latency beyond one cycle
// PATT  | capturing PATT_NUM*n pattern bytes
// PRBS  | capturing prbs_len PRBS bytes
// DONE  | completion pulse, last byte on the output
module prbs_seq_ctrl
   import prbs_seq_pkg::*;
#(
   parameter int PATT_W   = 8,
   parameter int PATT_NUM = 4,
   parameter int REP_W    = 5,
   parameter int LEN_W    = 16,
   parameter int GEN_LAT  = 1
) (
   input  logic                         clk,
   input  logic                         arst_n,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [PATT_W*PATT_NUM-1:0]   cfg_pattern,
   input  logic [REP_W-1:0]             cfg_n,
   input  logic [LEN_W-1:0]             cfg_prbs_len,
   input  logic                         start,
   input  logic                         abort,
   output logic                         gen_enable,
   output logic [REP_W-1:0]             gen_n,
   output logic [PATT_W*PATT_NUM-1:0]   gen_pattern,
   input  logic [PATT_W-1:0]            gen_byte,
   output logic [PATT_W-1:0]            out_byte,
   output logic                         out_valid,
   output logic                         out_sof,
   output logic                         out_eof,
   output logic [1:0]                   out_phase,
   output logic                         busy,
   output logic                         done
);

   localparam int PC_W   = REP_W + $clog2(PATT_NUM);
   localparam int WAIT_W = (GEN_LAT > 2) ? $clog2(GEN_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((GEN_LAT >= 2) ? GEN_LAT - 2 : 0);

   state_t                       state_q, state_nxt;
   logic [PATT_W*PATT_NUM-1:0]   pat_q;
   logic [REP_W-1:0]             n_q;
   logic [LEN_W-1:0]             len_q;
   logic                         cfg_loaded;
   logic [WAIT_W-1:0]            wait_q;
   logic                         first_q;
   logic [1:0]                   phase_q;

   logic cfg_fire, n_zero, len_zero, start_zero_run;
   logic patt_zero, prbs_zero, wait_zero, capture, last;

   assign cfg_ready  = (state_q == IDLE);
   assign cfg_fire   = cfg_valid && cfg_ready;
   assign n_zero     = (n_q == '0);
   assign len_zero   = (len_q == '0);
   // A same-cycle config transfer decides whether the run is empty.
   assign start_zero_run = cfg_fire ? ((cfg_n == '0) && (cfg_prbs_len == '0))
                                    : (n_zero && len_zero);
   assign wait_zero  = (wait_q == '0);
   assign capture    = ((state_q == PATT) || (state_q == PRBS)) && !abort;
   assign last       = ((state_q == PATT) && patt_zero && len_zero) ||
                       ((state_q == PRBS) && prbs_zero);

   // Configuration shadows; writable only while idle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pat_q      <= '0;
         n_q        <= '0;
         len_q      <= '0;
         cfg_loaded <= 1'b0;
      end else if (cfg_fire) begin
         pat_q      <= cfg_pattern;
         n_q        <= cfg_n;
         len_q      <= cfg_prbs_len;
         cfg_loaded <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state_q <= IDLE;
      else         state_q <= state_nxt;
   end

   // Next-state logic; abort wins over every other transition.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: if (start && !abort && (cfg_loaded || cfg_fire))
                  state_nxt = start_zero_run ? DONE : ARM;
         ARM:  if (abort)            state_nxt = IDLE;
               else if (GEN_LAT > 1) state_nxt = WAIT;
               else                  state_nxt = n_zero ? PRBS : PATT;
         WAIT: if (abort)            state_nxt = IDLE;
               else if (wait_zero)   state_nxt = n_zero ? PRBS : PATT;
         PATT: if (abort)            state_nxt = IDLE;
               else if (patt_zero)   state_nxt = len_zero ? DONE : PRBS;
         PRBS: if (abort)            state_nxt = IDLE;
               else if (prbs_zero)   state_nxt = DONE;
         DONE:                       state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Generator latency timer beyond the first cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         wait_q <= '0;
      else if (state_q == ARM)
         wait_q <= WAIT_LOAD;
      else if ((state_q == WAIT) && !wait_zero)
         wait_q <= wait_q - WAIT_W'(1);
   end

   // Counters hold (bytes remaining - 1) so the zero flag marks the last byte.
   seq_down_counter #(.W(PC_W)) u_patt_cnt (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (state_q == ARM),
      .load_val (PC_W'(n_q) * PC_W'(PATT_NUM) - PC_W'(1)),
      .dec      (state_q == PATT),
      .zero     (patt_zero)
   );

   seq_down_counter #(.W(LEN_W)) u_prbs_cnt (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (state_q == ARM),
      .load_val (len_q - LEN_W'(1)),
      .dec      (state_q == PRBS),
      .zero     (prbs_zero)
   );

   // Output stage: one register between the generator and downstream.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         out_byte  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         phase_q   <= PH_IDLE;
         first_q   <= 1'b0;
      end else begin
         if (state_q == ARM) first_q <= 1'b1;
         if (capture) begin
            out_byte  <= gen_byte;
            out_valid <= 1'b1;
            out_sof   <= first_q;
            out_eof   <= last;
            phase_q   <= (state_q == PATT) ? PH_PATT : PH_PRBS;
            first_q   <= 1'b0;
         end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            phase_q   <= PH_IDLE;
         end
      end
   end

   assign gen_enable  = (state_q == ARM);
   assign gen_n       = n_q;
   assign gen_pattern = pat_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign out_phase   = (state_q == DONE) ? PH_DONE : phase_q;

endmodule

// File: doc/prbs_seq_ctrl.md
Name: prbs_seq_ctrl

Overview:
Sequencing controller for the pattern/PRBS-15 byte generator. It accepts a run configuration over a valid/ready handshake: pattern words, repeat count n, and PRBS byte count. On start it arms the generator with a one-cycle enable pulse, then tracks the pattern phase and the PRBS phase. It forwards generator bytes downstream with valid/sof/eof/phase qualifiers and busy/done status. It sits between the test-mode register block and the byte generator.

Parameters:
PATT_W, 8, width of one pattern word and of every output byte
PATT_NUM, 4, pattern words per repetition
REP_W, 5, width of repeat count n
LEN_W, 16, width of PRBS byte count
GEN_LAT, 1, cycles from generator enable to stream byte 0 on gen_byte (must be >=1)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous reset, active-low
cfg_valid  in  1  configuration offered
cfg_ready  out  1  high only in IDLE; transfer when cfg_valid&&cfg_ready
cfg_pattern  in  PATT_W*PATT_NUM  pattern words; word i = [PATT_W*i +: PATT_W]
cfg_n  in  REP_W  pattern repetitions
cfg_prbs_len  in  LEN_W  PRBS bytes after the pattern phase
start  in  1  run request pulse
abort  in  1  terminate run
gen_enable  out  1  one-cycle arm pulse to generator
gen_n  out  REP_W  shadowed cfg_n
gen_pattern  out  PATT_W*PATT_NUM  shadowed cfg_pattern
gen_byte  in  PATT_W  generator byte stream
out_byte  out  PATT_W  registered copy of gen_byte
out_valid  out  1  out_byte belongs to the current run
out_sof  out  1  first valid byte of run
out_eof  out  1  last valid byte of run
out_phase  out  2  00 idle, 01 pattern, 10 prbs, 11 done
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): state IDLE; shadow registers, counters, out_byte = 0; cfg_loaded = 0. All control outputs = 0, except cfg_ready, which is 1.
- Config transfer: registers shadows and sets cfg_loaded; allowed only in IDLE. gen_n and gen_pattern are driven from the shadows at all times.
- start in IDLE with cfg_loaded=1 is accepted. start is ignored while busy or when cfg_loaded=0. A cfg transfer and start in the same cycle: start uses the new config.
- States: IDLE -> ARM -> WAIT (GEN_LAT-1 cycles, skipped if GEN_LAT=1) -> PATT -> PRBS -> DONE -> IDLE.
- ARM lasts one cycle with gen_enable=1. gen_enable is 0 in every other state.
- PATT captures exactly PATT_NUM*n consecutive gen_byte values, counted with a REP_W+clog2(PATT_NUM)-bit down-counter. PRBS then captures cfg_prbs_len bytes with a LEN_W down-counter.
- n=0: PATT is skipped and PRBS follows WAIT/ARM directly. prbs_len=0: DONE follows PATT.
- n=0 and prbs_len=0: start -> DONE next cycle; no gen_enable, no out_valid, and done is still pulsed.
- Output stage: one register. The byte captured in cycle c appears on out_byte/out_valid in cycle c+1, with out_phase 01 or 10.
- Latency with GEN_LAT=1: start at cycle 0, gen_enable at cycle 1, first out_valid+out_sof at cycle 3.
- out_sof is on the first valid byte only. out_eof is on the last valid byte only; both are set if the run has a single byte.
- done=1 and out_phase=11 hold for exactly the DONE cycle, which coincides with out_eof. Return to IDLE follows on the next cycle.
- out_byte keeps the last value when out_valid=0.
- abort (any state except IDLE): next cycle IDLE, with out_valid/sof/eof = 0, no done, and cfg_loaded kept. abort in IDLE is a no-op. abort beats start in the same cycle.
- Counters never wrap: maximum n = 2^REP_W-1 and maximum prbs_len = 2^LEN_W-1 are handled without overflow.

Decomposition:
- Package prbs_seq_pkg: state enum (IDLE, ARM, WAIT, PATT, PRBS, DONE) and phase encoding constants PH_IDLE/PH_PATT/PH_PRBS/PH_DONE.
- One sub-module seq_down_counter (parameterised width; load, decrement, zero flag). It is instantiated for the pattern counter and the PRBS counter.

Test Plan:
- Load pattern 0xDDCCBBAA, n=2, prbs_len=3, start -> gen_enable at cycle 1. Eleven out_valid bytes from cycle 3: eight phase-01 bytes, then three phase-10 bytes. sof on byte 0; eof and done together on byte 10.
- n=0, prbs_len=5 -> one gen_enable, five phase-10 bytes, no phase-01 bytes, done with eof.
- n=0, prbs_len=0, start -> no gen_enable, no out_valid, done at cycle 1.
- start while busy, and start before any cfg transfer -> ignored. cfg_ready=0 during the run; cfg_valid while busy leaves the shadows unchanged.
- abort during PATT after 3 bytes -> out_valid low next cycle, busy=0, no done; a following start reruns the same config from sof.
- arst_n asserted mid-PRBS -> all outputs reset immediately; after release cfg_ready=1 and start is ignored until a new cfg transfer.
